hazard_unit: RTL and testbench

Pipeline interlock and forwarding controller for the 16-bit CPU. It tracks register writes in flight through the X (ALU) and W (writeback) stages as a two-entry scoreboard, with byte-enable awareness. Each cycle it compares the decode-stage operand addresses against the scoreboard and produces the `data_hazard` stall that freezes the ALU and decode. It also produces operand-forwarding selects for the A and B operand muxes, and keeps a saturating stall counter for performance measurement.

---
 rtl/hazard_unit.sv | 89 ++++++++
 tb/tb_hazard_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline interlock and operand-forwarding controller: two-entry (X, W) write
// scoreboard with byte-enable awareness and a saturating stall counter.
module hazard_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_a_sel,
  input  logic [REG_W-1:0] d_b_sel,
  input  logic             d_uses_a,
  input  logic             d_uses_b,
  input  logic             d_wr,
  input  logic [REG_W-1:0] d_dest,
  input  logic             d_h_en,
  input  logic             d_l_en,
  input  logic             d_load,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             data_hazard,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic [1:0]       mask;
    logic             load;
  } sb_entry_t;

  sb_entry_t x_q;
  sb_entry_t w_q;

  logic       swap;
  logic [1:0] d_mask;
  logic       live;
  logic       issue;
  logic [2:0] res_a;
  logic [2:0] res_b;

  // Result is {hazard, fwd}. X is younger than W, so it is looked at first.
  function automatic logic [2:0] check_src(input logic [REG_W-1:0] s,
                                           input sb_entry_t x,
                                           input sb_entry_t w);
    logic [2:0] r;
    r = 3'b000;
    if (x.valid && x.dest == s) begin
      if (x.load || x.mask != 2'b11) r = 3'b100;
      else                           r = 3'b001;
    end else if (w.valid && w.dest == s) begin
      if (w.mask != 2'b11) r = 3'b100;
      else                 r = 3'b010;
    end
    return r;
  endfunction

  always_comb begin
    swap        = ~d_h_en & ~d_l_en;
    d_mask      = {d_h_en | swap, d_l_en | swap};
    live        = d_valid & ~flush;
    res_a       = check_src(d_a_sel, x_q, w_q);
    res_b       = check_src(d_b_sel, x_q, w_q);
    data_hazard = live & ((d_uses_a & res_a[2]) | (d_uses_b & res_b[2]));
    fwd_a       = (live && d_uses_a) ? res_a[1:0] : 2'b00;
    fwd_b       = (live && d_uses_b) ? res_b[1:0] : 2'b00;
    issue       = live & ~data_hazard;
  end

  // A stalled cycle inserts a bubble into X while W keeps draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      w_q         <= '0;
      stall_count <= '0;
    end else begin
      w_q <= x_q;
      if (issue && d_wr) x_q <= {1'b1, d_dest, d_mask, d_load};
      else               x_q <= '0;
      if (cnt_clr)
        stall_count <= '0;
      else if (data_hazard && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic, checked each
// cycle against a list-of-in-flight-writes reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid, d_uses_a, d_uses_b, d_wr, d_h_en, d_l_en, d_load;
  logic [3:0] d_a_sel, d_b_sel, d_dest;
  logic       flush, cnt_clr;
  logic       data_hazard;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] stall_count;

  hazard_unit #(.REG_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_a_sel(d_a_sel),
    .d_b_sel(d_b_sel), .d_uses_a(d_uses_a), .d_uses_b(d_uses_b), .d_wr(d_wr),
    .d_dest(d_dest), .d_h_en(d_h_en), .d_l_en(d_l_en), .d_load(d_load),
    .flush(flush), .cnt_clr(cnt_clr), .data_hazard(data_hazard),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // reference model: in-flight writes, index 0 is the youngest
  typedef struct {
    logic       v;
    logic [3:0] dest;
    logic       full;
    logic       ld;
  } write_t;
  write_t inflight[$];
  int     model_cnt;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    write_t b;
    b = '{v: 1'b0, dest: 4'd0, full: 1'b0, ld: 1'b0};
    inflight.delete();
    inflight.push_back(b);
    inflight.push_back(b);
    model_cnt = 0;
  endtask

  // Youngest matching write decides. Age 0 result exists only as ALU output
  // of a whole-word non-load; age 1 is on the writeback bus if whole-word.
  task automatic src_eval(input logic [3:0] s, output logic haz, output logic [1:0] fwd);
    logic found;
    found = 1'b0;
    haz   = 1'b0;
    fwd   = 2'b00;
    for (int age = 0; age < 2; age++) begin
      if (!found && inflight[age].v && inflight[age].dest == s) begin
        found = 1'b1;
        if (age == 0 && inflight[age].full && !inflight[age].ld) fwd = 2'b01;
        else if (age == 1 && inflight[age].full)                fwd = 2'b10;
        else                                                    haz = 1'b1;
      end
    end
  endtask

  task automatic model_eval(output logic haz, output logic [1:0] fa, output logic [1:0] fb);
    logic ha, hb;
    logic [1:0] ra, rb;
    src_eval(d_a_sel, ha, ra);
    src_eval(d_b_sel, hb, rb);
    if (!d_valid || flush) begin
      haz = 1'b0; fa = 2'b00; fb = 2'b00;
    end else begin
      haz = (d_uses_a && ha) || (d_uses_b && hb);
      fa  = d_uses_a ? ra : 2'b00;
      fb  = d_uses_b ? rb : 2'b00;
    end
  endtask

  task automatic model_advance(input logic haz, input logic clr);
    write_t n;
    n = '{v: 1'b0, dest: 4'd0, full: 1'b0, ld: 1'b0};
    if (d_valid && !flush && !haz && d_wr)
      n = '{v: 1'b1, dest: d_dest, full: (d_h_en == d_l_en), ld: d_load};
    inflight.push_front(n);
    void'(inflight.pop_back());
    if (clr)      model_cnt = 0;
    else if (haz) model_cnt = (model_cnt + 1 > 255) ? 255 : model_cnt + 1;
  endtask

  // driver tasks
  task automatic set_in(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic ua, input logic ub, input logic wr,
                        input logic [3:0] dst, input logic h, input logic l,
                        input logic ld, input logic fl);
    d_valid = v; d_a_sel = a; d_b_sel = b; d_uses_a = ua; d_uses_b = ub;
    d_wr = wr; d_dest = dst; d_h_en = h; d_l_en = l; d_load = ld; flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge: check outputs, then cross one rising edge.
  task automatic tick(input logic clr);
    logic       eh;
    logic [1:0] efa, efb;
    cnt_clr = clr;
    #1;
    model_eval(eh, efa, efb);
    exp_q.push_back({7'd0, eh});
    exp_q.push_back({6'd0, efa});
    exp_q.push_back({6'd0, efb});
    exp_q.push_back(8'(model_cnt));
    check("data_hazard", data_hazard, exp_q.pop_front());
    check("fwd_a", fwd_a, exp_q.pop_front());
    check("fwd_b", fwd_b, exp_q.pop_front());
    check("stall_count", stall_count, exp_q.pop_front());
    @(posedge clk);
    model_advance(eh, clr);
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_hazard", data_hazard, 0);
    check("rst_count", stall_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    tick(0);

    // back-to-back ALU dependency, then one cycle later via writeback
    set_in(1, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0); tick(0);
    set_in(1, 3, 0, 1, 0, 0, 0, 1, 1, 0, 0); tick(0);
    set_in(1, 3, 0, 1, 0, 0, 0, 1, 1, 0, 0); tick(0);
    idle(); tick(1); tick(0);

    // load-use
    set_in(1, 0, 0, 0, 0, 1, 5, 1, 1, 1, 0); tick(0);
    set_in(1, 0, 5, 0, 1, 0, 0, 1, 1, 0, 0); tick(0); tick(0);
    idle();
    check("load_use_cnt", stall_count, 1);
    tick(1); tick(0);

    // partial byte, then swap
    set_in(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0); tick(0);
    set_in(1, 2, 2, 1, 1, 0, 0, 1, 1, 0, 0); tick(0); tick(0); tick(0);
    idle();
    check("partial_cnt", stall_count, 2);
    tick(0); tick(0);
    set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0); tick(0);
    set_in(1, 2, 0, 1, 0, 0, 0, 1, 1, 0, 0); tick(0);
    idle(); tick(0); tick(0);

    // priority: X wins over W
    set_in(1, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0); tick(0); tick(0);
    set_in(1, 7, 7, 1, 1, 0, 0, 1, 1, 0, 0); tick(0);
    idle(); tick(0); tick(0);

    // flush during load-use, unused source against an X load
    set_in(1, 0, 0, 0, 0, 1, 5, 1, 1, 1, 0); tick(0);
    set_in(1, 0, 5, 0, 1, 0, 0, 1, 1, 0, 1); tick(0);
    idle(); tick(0);
    set_in(1, 0, 0, 0, 0, 1, 6, 1, 1, 1, 0); tick(0);
    set_in(1, 6, 0, 0, 1, 0, 0, 1, 1, 0, 0); tick(0);
    idle(); tick(0); tick(0);

    // reset asserted mid-stall
    set_in(1, 0, 0, 0, 0, 1, 5, 1, 1, 1, 0); tick(0);
    set_in(1, 0, 5, 0, 1, 0, 0, 1, 1, 0, 0);
    #1;
    check("pre_rst_hazard", data_hazard, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hazard", data_hazard, 0);
    check("mid_rst_count", stall_count, 0);
    check("mid_rst_fwd_b", fwd_b, 0);
    model_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick(0);

    // saturation: 150 partial-byte pairs give 300 stall cycles
    for (int i = 0; i < 150; i++) begin
      set_in(1, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0); tick(0);
      set_in(1, 2, 0, 1, 0, 0, 0, 1, 1, 0, 0); tick(0); tick(0); tick(0);
    end
    idle();
    check("sat_cnt", stall_count, 255);
    tick(1);
    check("clr_cnt", stall_count, 0);
    tick(0);

    // random traffic with a small register range to force collisions
    for (int i = 0; i < 500; i++) begin
      set_in(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      tick($urandom_range(0, 29) == 0);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
